// File: rtl/pipe_ctrl_gen.sv
// pipe_ctrl_gen
//   Pipeline control unit for the OpenMIPS core. Builds per-stage stall
//   masks from stall requests, converts exceptions into a registered
//   multi-cycle flush with a redirect PC, keeps a programmable exception
//   base, and provides a stall watchdog and a stall-cycle counter.
//
// Ports
//   clk             : clock, all state on rising edge
//   rst             : asynchronous active-high reset
//   stallreq_i      : [STAGES-2:0] stall request, bit k from stage k
//   excepttype_i    : [DW-1:0] exception code from MEM, 0 = none
//   cp0_epc_i       : [DW-1:0] EPC used as target for eret (code 0x0e)
//   ebase_we_i      : exception base write enable
//   ebase_i         : [DW-1:0] new exception base, bits [11:0] forced to 0
//   wdog_clr_i      : clears the sticky watchdog flag and its counter
//   stall           : [STAGES-1:0] per-stage hold, bit k holds stage k
//   flush           : flush all pipeline registers
//   new_pc          : [DW-1:0] redirect PC, valid while flush = 1
//   stall_timeout_o : sticky watchdog timeout flag
//   stall_cycles_o  : [31:0] saturating count of stalled cycles
module pipe_ctrl_gen #(
  parameter int              STAGES     = 6,
  parameter int              DW         = 32,
  parameter int              FLUSH_LEN  = 1,
  parameter logic [DW-1:0]   EBASE_RST  = '0,
  parameter int              WDOG_LIMIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-2:0] stallreq_i,
  input  logic [DW-1:0]     excepttype_i,
  input  logic [DW-1:0]     cp0_epc_i,
  input  logic              ebase_we_i,
  input  logic [DW-1:0]     ebase_i,
  input  logic              wdog_clr_i,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [DW-1:0]     new_pc,
  output logic              stall_timeout_o,
  output logic [31:0]       stall_cycles_o
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam int            WDW        = 16;
  localparam logic [WDW-1:0] WDOG_MAX  = WDW'(WDOG_LIMIT);
  localparam logic [3:0]    FLUSH_INIT = 4'(FLUSH_LEN);

  // The exception base is always 4 KiB aligned.
  localparam logic [DW-1:0] EBASE_MASK = ~DW'(12'hFFF);

  localparam logic [DW-1:0] CODE_INT  = DW'(32'h01);
  localparam logic [DW-1:0] CODE_ERET = DW'(32'h0e);
  localparam logic [DW-1:0] OFS_INT   = DW'(32'h20);
  localparam logic [DW-1:0] OFS_GEN   = DW'(32'h40);

  // Saturating increment for the 32-bit performance counter.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end
    return v + 32'd1;
  endfunction

  // Saturating increment for the watchdog, pinned at the limit.
  function automatic logic [WDW-1:0] wdog_inc(input logic [WDW-1:0] v);
    if (v >= WDOG_MAX) begin
      return WDOG_MAX;
    end
    return v + 1'b1;
  endfunction

  // Redirect target for an exception code. Interrupts use the +0x20
  // vector, eret returns to EPC, every other nonzero code (including
  // syscall/break/overflow/trap) shares the general +0x40 vector.
  function automatic logic [DW-1:0] vector_sel(
    input logic [DW-1:0] code,
    input logic [DW-1:0] base,
    input logic [DW-1:0] epc
  );
    if (code == CODE_INT) begin
      return base + OFS_INT;
    end
    if (code == CODE_ERET) begin
      return epc;
    end
    return base + OFS_GEN;
  endfunction

  logic [0:0]        state;
  logic [3:0]        flush_cnt;
  logic [DW-1:0]     ebase;
  logic [WDW-1:0]    wdog_cnt;
  logic [STAGES-1:0] stall_mask;
  logic              exc_any;
  logic              stall_any;

  assign exc_any = (excepttype_i != '0);

  // Stage k is held when it or any younger-numbered-than-requester
  // stage, i.e. any stage at or above k, requests a stall. This yields
  // bits [m:0] for the highest requester m. The WB stage is never held.
  always_comb begin
    stall_mask = '0;
    for (int k = 0; k < STAGES - 1; k++) begin
      stall_mask[k] = |(stallreq_i >> k);
    end
  end

  // Exceptions override stalls; nothing is held while flushing.
  always_comb begin
    stall = '0;
    if (state == ST_RUN && !exc_any) begin
      stall = stall_mask;
    end
  end

  assign stall_any = (stall != '0);
  assign flush     = (state == ST_FLUSH);

  // Control stage: RUN/FLUSH sequencing and redirect target capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
      new_pc    <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (exc_any) begin
            state     <= ST_FLUSH;
            flush_cnt <= FLUSH_INIT;
            new_pc    <= vector_sel(excepttype_i, ebase, cp0_epc_i);
          end
        end
        ST_FLUSH: begin
          // Codes seen here belong to instructions being flushed.
          if (flush_cnt == 4'd1) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
            new_pc    <= '0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          state     <= ST_RUN;
          flush_cnt <= '0;
          new_pc    <= '0;
        end
      endcase
    end
  end

  // Exception base register; an exception in the write cycle still
  // sees the previous value because the capture above reads the
  // registered copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ebase <= EBASE_RST & EBASE_MASK;
    end else if (ebase_we_i) begin
      ebase <= ebase_i & EBASE_MASK;
    end
  end

  // Watchdog and performance counter stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt        <= '0;
      stall_timeout_o <= 1'b0;
      stall_cycles_o  <= '0;
    end else begin
      if (wdog_clr_i) begin
        wdog_cnt        <= '0;
        stall_timeout_o <= 1'b0;
      end else if (stall_any) begin
        wdog_cnt <= wdog_inc(wdog_cnt);
        if (wdog_cnt >= WDOG_MAX - 1'b1) begin
          stall_timeout_o <= 1'b1;
        end
      end else begin
        wdog_cnt <= '0;
      end

      if (stall_any) begin
        stall_cycles_o <= sat_inc32(stall_cycles_o);
      end
    end
  end

endmodule

// File: doc/pipe_ctrl_gen.md
# pipe_ctrl_gen

Parametrised pipeline control unit for the OpenMIPS core, successor to the fixed six-stage stall/flush controller. It builds per-stage stall masks from a vector of stall requests and turns exceptions into a registered, multi-cycle flush with a target PC. The exception vector base is programmable. A stall watchdog and a stall-cycle performance counter are included. It sits beside the pipeline registers and drives their `stall`/`flush` inputs and the PC register's `new_pc` path.

## Interface
- `STAGES`, 6, number of pipeline stages (stage 0 = PC … stage STAGES-1 = WB); range 3..16
- `DW`, 32, data/address width
- `FLUSH_LEN`, 1, cycles `flush` stays high per exception; range 1..15
- `EBASE_RST`, 32'h00000000, reset value of exception base
- `WDOG_LIMIT`, 255, consecutive stalled cycles before timeout; range 1..2^16-1
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: asynchronous, active-high reset
- `stallreq_i` in STAGES-1: bit k = stall request from stage k
- `excepttype_i` in DW: exception code from MEM; 0 = none
- `cp0_epc_i` in DW: EPC for eret
- `ebase_we_i` in 1: write enable for exception base
- `ebase_i` in DW: new exception base; bits [11:0] ignored, stored as 0
- `wdog_clr_i` in 1: clears sticky timeout
- `stall` out STAGES: bit k = hold stage k register
- `flush` out 1: flush all pipeline registers
- `new_pc` out DW: redirect PC, valid while `flush`=1
- `stall_timeout_o` out 1: sticky watchdog flag
- `stall_cycles_o` out 32: saturating count of cycles with `stall`≠0

## Operation
- FSM states RUN and FLUSH. Reset: RUN, `flush`=0, `new_pc`=0, `stall`=0, ebase=EBASE_RST & ~12'hFFF, timeout=0, counters=0.
- Stall mask is combinational in RUN with `excepttype_i`=0. Let m = highest set k in `stallreq_i`. Then `stall` = bits [m:0] set, all others 0. If no request, `stall`=0. Bit STAGES-1 is never set.
- `stall` is forced to 0 in FLUSH, and in any RUN cycle with `excepttype_i`≠0. Exceptions take priority over stalls.
- RUN with `excepttype_i`≠0: register `new_pc`, load flush counter with FLUSH_LEN, go to FLUSH.
- Vector selection:
  - code 0x01 → ebase+0x20
  - codes 0x08, 0x0a, 0x0c, 0x0d → ebase+0x40
  - code 0x0e → `cp0_epc_i` sampled in the same cycle
  - any other nonzero code → ebase+0x40
  - ebase additions wrap modulo 2^DW.
- FLUSH: `flush`=1 and `new_pc` holds. Counter decrements each cycle. `excepttype_i` is ignored because it comes from flushed instructions. Exit to RUN when the counter reaches 1. `new_pc` returns to 0 on exit.
- ebase write takes effect the next cycle in any state. A write in the same cycle as an exception uses the old ebase.
- Watchdog counter:
  - increments each cycle `stall`≠0 and resets to 0 when `stall`=0.
  - at WDOG_LIMIT it sets `stall_timeout_o` and holds the count.
  - `wdog_clr_i` clears the flag and the counter. If clear and set coincide, clear wins.
- `stall_cycles_o` increments on each cycle `stall`≠0 and saturates at 32'hFFFFFFFF.

## Timing
- `stall` has 0-cycle latency from `stallreq_i`/`excepttype_i` (combinational).
- Exception presented in cycle t gives `flush`=1 and valid `new_pc` in cycles t+1 … t+FLUSH_LEN, then RUN at t+FLUSH_LEN+1.
- Back-to-back exceptions: only one is taken per flush window. A new one is accepted in the first RUN cycle.
- `rst` asserted mid-flush immediately drops `flush` and zeroes `new_pc`, independent of `clk`.
- Counters and timeout update on the clock edge after the stalled cycle.

## Test plan
- Reset defaults, STAGES=6: `stallreq_i`=5'b01000 → `stall`=6'b001111. Requests 5'b10001 → 6'b011111. Requests 0 → 0.
- Default ebase, FLUSH_LEN=3: `excepttype_i`=0x08 at t → `flush`=1 with `new_pc`=0x40 for t+1..t+3. `stall`=0 at t even with `stallreq_i`=5'b11111.
- Write ebase 0xBFC01234 → stored 0xBFC01000. Interrupt 0x01 → `new_pc`=0xBFC01020. Code 0x0e with EPC 0x80001234 → `new_pc`=0x80001234. Unknown code 0x17 → 0xBFC01040.
- Exception 0x0c during FLUSH → ignored. Re-presented in the first RUN cycle → second flush follows.
- WDOG_LIMIT=4: hold `stallreq_i`[2] for 4 cycles → `stall_timeout_o`=1 after the 4th edge and stays high after the request drops. `wdog_clr_i` → 0. `stall_cycles_o`=4.
- Assert `rst` asynchronously mid-flush → `flush`=0, `new_pc`=0, ebase=EBASE_RST, counters=0 before the next clock edge.
